// File: rtl/pp_link_pkg.sv
// pp_link_pkg: shared FSM encoding and default constants for the Pi parallel-port link.
package pp_link_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SETTLE_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 65535;
  localparam logic [DATA_W-1:0] FILL_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_ACK    = 3'd1,
    ST_TX_WAIT   = 3'd2,
    ST_TX_SETTLE = 3'd3,
    ST_TX_ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/pp_sync.sv
// pp_sync: W-bit two-flop synchroniser for asynchronous pin inputs, with a reset value.
module pp_sync #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule

// File: rtl/pp_link.sv
// pp_link: handshaken byte link between the Raspberry Pi parallel port and the fabric.
// Optional read-request timeout is built when the macro PP_TIMEOUT_EN is defined.
module pp_link
  import pp_link_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES  = SETTLE_DEF,
  parameter int unsigned        TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0]  FILL_BYTE      = FILL_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output logic              o_rx_stb,
  output logic [DATA_W-1:0] o_rx_data,
  input  logic              i_tx_stb,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_busy,
  input  logic              i_pp_dir,
  input  logic              i_pp_clk,
  input  logic [DATA_W-1:0] i_pp_data,
  output logic [DATA_W-1:0] o_pp_data,
  output logic              o_pp_oe,
  output logic              o_pp_clkfb
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic              clk_s, dir_s, clk_d_q, rise, abort, load, pop;
  logic [DATA_W-1:0] data_s;
  state_t            state_q, state_d;
  logic              req_dir_q, req_dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rx_stb_q, rx_stb_d, clkfb_q, clkfb_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, pp_data_q, pp_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic              settle_done_c, tmo_done_c;

  pp_sync #(.W(1), .RST_VAL(1'b0)) u_sync_clk (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_pp_clk), .o_q(clk_s));
  pp_sync #(.W(1), .RST_VAL(1'b1)) u_sync_dir (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_pp_dir), .o_q(dir_s));
  pp_sync #(.W(DATA_W), .RST_VAL('0)) u_sync_data (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_pp_data), .o_q(data_s));

  assign rise          = clk_s & ~clk_d_q;
  assign abort         = (state_q != ST_IDLE) && (dir_s != req_dir_q);
  assign load          = i_tx_stb && !full_q;
  assign settle_done_c = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

`ifdef PP_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  assign tmo_done_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg_c;
  assign tmo_done_c   = 1'b0;
  assign unused_cfg_c = ^{FILL_BYTE, TIMEOUT_CYCLES[0]};
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a direction change mid-handshake aborts back to IDLE.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (rise) state_d = dir_s ? ST_RX_ACK : ST_TX_WAIT;
        ST_RX_ACK:    if (!clk_s) state_d = ST_IDLE;
        ST_TX_WAIT:   if (full_q || tmo_done_c) state_d = ST_TX_SETTLE;
        ST_TX_SETTLE: if (settle_done_c) state_d = ST_TX_ACK;
        ST_TX_ACK:    if (!clk_s) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: strobes, acknowledge, pin data and holding register.
  always_comb begin
    rx_stb_d  = 1'b0;
    rx_data_d = rx_data_q;
    clkfb_d   = clkfb_q;
    pp_data_d = pp_data_q;
    req_dir_d = req_dir_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
`ifdef PP_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    if (abort) begin
      clkfb_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            req_dir_d = dir_s;
`ifdef PP_TIMEOUT_EN
            tmo_d     = '0;
`endif
            if (dir_s) begin
              rx_data_d = data_s;
              rx_stb_d  = 1'b1;
              clkfb_d   = 1'b1;
            end
          end
        end
        ST_RX_ACK, ST_TX_ACK: if (!clk_s) clkfb_d = 1'b0;
        ST_TX_WAIT: begin
          if (full_q) begin
            pp_data_d = hold_q;
            pop       = 1'b1;
            cnt_d     = '0;
          end else if (tmo_done_c) begin
`ifdef PP_TIMEOUT_EN
            pp_data_d = FILL_BYTE;
`endif
            cnt_d     = '0;
          end
`ifdef PP_TIMEOUT_EN
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
        ST_TX_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (settle_done_c) clkfb_d = 1'b1;
        end
        default: ;
      endcase
    end
    // A pop only happens while full, so it never coincides with a load.
    full_d = pop ? 1'b0 : (load ? 1'b1 : full_q);
    hold_d = load ? i_tx_data : hold_q;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clk_d_q   <= 1'b0;
      rx_stb_q  <= 1'b0;
      rx_data_q <= '0;
      clkfb_q   <= 1'b0;
      pp_data_q <= '0;
      req_dir_q <= 1'b1;
      cnt_q     <= '0;
      hold_q    <= '0;
      full_q    <= 1'b0;
    end else begin
      clk_d_q   <= clk_s;
      rx_stb_q  <= rx_stb_d;
      rx_data_q <= rx_data_d;
      clkfb_q   <= clkfb_d;
      pp_data_q <= pp_data_d;
      req_dir_q <= req_dir_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
    end
  end

`ifdef PP_TIMEOUT_EN
  // Read-request wait counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end
`endif

  assign o_rx_stb   = rx_stb_q;
  assign o_rx_data  = rx_data_q;
  assign o_tx_busy  = full_q;
  assign o_pp_data  = pp_data_q;
  assign o_pp_oe    = ~dir_s;
  assign o_pp_clkfb = clkfb_q;

endmodule
